// File: rtl/counter_down_n_if.sv
// Interface bundling the control and status signals of counter_down_n.
// Ports (from the controller's point of view, modport master):
//   load  - load strobe; din != 0 starts a count, din == 0 aborts
//   din   - N-bit load value
//   en    - count enable
//   auto  - 1 = auto-reload at terminal count, 0 = one-shot
//   count - current counter value          (from the counter)
//   busy  - counter is running             (from the counter)
//   tc    - one-cycle terminal-count pulse (from the counter)
//   done  - one-shot has expired           (from the counter)
// clk and the asynchronous reset stay plain ports on the counter itself.
interface counter_down_n_if #(
    parameter int N = 6
);
    logic         load;
    logic [N-1:0] din;
    logic         en;
    logic         auto;
    logic [N-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    modport master (
        output load, din, en, auto,
        input  count, busy, tc, done
    );

    modport slave (
        input  load, din, en, auto,
        output count, busy, tc, done
    );
endinterface

// File: rtl/counter_down_n.sv
// Loadable N-bit down-counter / interval timer with one-shot and auto-reload
// modes. All state changes on the falling edge of clk; clr is an asynchronous
// active-low reset.
// Ports:
//   clk - clock, active on the falling edge
//   clr - asynchronous reset, active low
//   bus - counter_down_n_if slave modport (load, din, en, auto in;
//         count, busy, tc, done out, all outputs registered)
module counter_down_n #(
    parameter int N = 6
) (
    input  logic              clk,
    input  logic              clr,
    counter_down_n_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q,  state_d;
    logic [N-1:0] count_q,  count_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q,     tc_d;
    logic         busy_q,   busy_d;
    logic         done_q,   done_d;

    // Next-state logic: load beats terminal count, which beats decrement.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            if (bus.din != CNT_ZERO) begin
                count_d  = bus.din;
                reload_d = bus.din;
                state_d  = ST_RUN;
            end else begin
                // Abort: the reload value is deliberately kept.
                count_d  = CNT_ZERO;
                state_d  = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.en) begin
                        // Treating anything <= 1 as terminal keeps the count
                        // from ever wrapping below zero.
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            tc_d = 1'b1;
                            if (bus.auto) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CNT_ZERO;
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_DONE: begin
                    count_d = CNT_ZERO;
                end
                ST_IDLE: begin
                    count_d = CNT_ZERO;
                end
                default: begin
                    count_d = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags follow the next state so they leave the flops
        // aligned with the state register.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs, falling-edge clocked with async clear.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule
